// File: rtl/spi_transaction_fsm_pkg.sv
// rtl/spi_transaction_fsm_pkg.sv - shared types and constants for the SPI transaction FSM
package spi_transaction_fsm_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_LATCH_ADDR,
        ST_READ_LOAD,
        ST_READ_SHIFT,
        ST_WRITE_GET,
        ST_WRITE_MEM,
        ST_DONE
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - saturating SCLK edge counter with synchronous clear
module spi_bit_counter
    import spi_transaction_fsm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    localparam int CW   = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          done
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign done  = (count_q == CW'(WIDTH));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && !done) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spi_transaction_fsm.sv
// rtl/spi_transaction_fsm.sv - Moore FSM sequencing SPI address, read and write phases
module spi_transaction_fsm
    import spi_transaction_fsm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic csConditioned,
    input  logic sclkPosEdge,
    input  logic rwBit,
    output logic addrWE,
    output logic srWE,
    output logic dmWE,
    output logic misoBufE
);

    localparam int CW = cnt_width(WIDTH);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_count;
    logic          cnt_done;
    logic          cnt_inc;
    logic          cnt_clear;
    logic          counting;
    logic          last_bit;

    spi_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (cnt_count),
        .done  (cnt_done)
    );

    assign counting = (state_q == ST_GET_ADDR) || (state_q == ST_READ_SHIFT) ||
                      (state_q == ST_WRITE_GET);
    // A pulse arriving with cs already released belongs to no transaction.
    assign cnt_inc  = counting && sclkPosEdge && !csConditioned;
    // Leave a counting state on the same edge that registers the final pulse.
    assign last_bit = cnt_inc && (cnt_count == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (!csConditioned) state_d = ST_GET_ADDR;
            ST_GET_ADDR:   if (last_bit || cnt_done) state_d = ST_LATCH_ADDR;
            ST_LATCH_ADDR: state_d = rwBit ? ST_READ_LOAD : ST_WRITE_GET;
            ST_READ_LOAD:  state_d = ST_READ_SHIFT;
            ST_READ_SHIFT: if (last_bit || cnt_done) state_d = ST_DONE;
            ST_WRITE_GET:  if (last_bit || cnt_done) state_d = ST_WRITE_MEM;
            ST_WRITE_MEM:  state_d = ST_DONE;
            ST_DONE:       if (csConditioned) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
        if ((state_q != ST_IDLE) && csConditioned) begin
            state_d = ST_IDLE;
        end
    end

    assign cnt_clear = (state_d != state_q);

    always_comb begin
        addrWE   = (state_q == ST_LATCH_ADDR);
        srWE     = (state_q == ST_READ_LOAD);
        dmWE     = (state_q == ST_WRITE_MEM);
        misoBufE = (state_q == ST_READ_SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// tb/tb_spi_transaction_fsm.sv - self-checking bench for spi_transaction_fsm
module tb_spi_transaction_fsm;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cs = 1'b1;
    logic sclk = 1'b0;
    logic rw = 1'b0;
    logic addr_we, sr_we, dm_we, miso_e;

    int total = 0;
    int bad = 0;
    int n_addr = 0, n_sr = 0, n_dm = 0, n_miso = 0;

    // Transaction progress: p counts completed events (pulses and one-cycle steps).
    // Read : W pulses, latch, load, W pulses -> 2W+2.  Write: W pulses, latch, W pulses, mem -> 2W+2.
    bit busy = 1'b0;
    int p = 0;
    bit mrw = 1'b0;

    spi_transaction_fsm #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .csConditioned (cs),
        .sclkPosEdge   (sclk),
        .rwBit         (rw),
        .addrWE        (addr_we),
        .srWE          (sr_we),
        .dmWE          (dm_we),
        .misoBufE      (miso_e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit need_pulse();
        return (p < W) || (mrw && p >= W + 2 && p <= 2 * W + 1) ||
               (!mrw && p >= W + 1 && p <= 2 * W);
    endfunction

    task automatic model_step();
        if (!busy) begin
            if (!cs) begin
                busy = 1'b1;
                p = 0;
            end
        end else if (cs) begin
            busy = 1'b0;
        end else if (p == W) begin
            mrw = rw;
            p++;
        end else if ((mrw && p == W + 1) || (!mrw && p == 2 * W + 1)) begin
            p++;
        end else if (sclk && need_pulse()) begin
            p++;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic ea, es, ed, em;
        ea = busy && p == W;
        es = busy && mrw && p == W + 1;
        em = busy && mrw && p >= W + 2 && p <= 2 * W + 1;
        ed = busy && !mrw && p == 2 * W + 1;
        chk({tag, "_addrWE"}, addr_we, ea);
        chk({tag, "_srWE"}, sr_we, es);
        chk({tag, "_dmWE"}, dm_we, ed);
        chk({tag, "_misoBufE"}, miso_e, em);
        chk({tag, "_strobe_excl"}, logic'($onehot0({addr_we, sr_we, dm_we})), 1'b1);
        n_addr += int'(addr_we);
        n_sr   += int'(sr_we);
        n_dm   += int'(dm_we);
        n_miso += int'(miso_e);
    endtask

    task automatic clr_cnt();
        n_addr = 0; n_sr = 0; n_dm = 0; n_miso = 0;
    endtask

    task automatic cyc(input logic c, input logic s, input logic r, input string tag);
        @(negedge clk);
        cs = c; sclk = s; rw = r;
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic pulses(input int n, input logic r, input string tag);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, r, tag);
            cyc(1'b0, 1'b0, r, tag);
        end
    endtask

    initial begin
        // Reset state, before any clock edge
        #2;
        chk("rst_addrWE", addr_we, 1'b0);
        chk("rst_srWE", sr_we, 1'b0);
        chk("rst_dmWE", dm_we, 1'b0);
        chk("rst_misoBufE", miso_e, 1'b0);
        chk_int("rst_count", int'(dut.u_bit_counter.count), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, "idle_cs_high");

        // Write transaction followed by extra pulses in DONE
        clr_cnt();
        cyc(1'b0, 1'b0, 1'b0, "wr_start");
        pulses(W, 1'b0, "wr_addr");
        cyc(1'b0, 1'b0, 1'b0, "wr_gap");
        pulses(W, 1'b0, "wr_data");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, "wr_done_pulse");
        chk_int("wr_n_addr", n_addr, 1);
        chk_int("wr_n_dm", n_dm, 1);
        chk_int("wr_n_sr", n_sr, 0);
        chk_int("wr_n_miso", n_miso, 0);
        cyc(1'b1, 1'b0, 1'b0, "wr_release");

        // Read transaction, back-to-back pulses
        clr_cnt();
        cyc(1'b0, 1'b0, 1'b1, "rd_start");
        for (int i = 0; i < W; i++) cyc(1'b0, 1'b1, 1'b1, "rd_addr");
        cyc(1'b0, 1'b0, 1'b1, "rd_latch");
        cyc(1'b0, 1'b0, 1'b1, "rd_load");
        for (int i = 0; i < W; i++) cyc(1'b0, 1'b1, 1'b1, "rd_shift");
        cyc(1'b0, 1'b0, 1'b1, "rd_done");
        chk_int("rd_n_addr", n_addr, 1);
        chk_int("rd_n_sr", n_sr, 1);
        chk_int("rd_n_dm", n_dm, 0);
        chk_int("rd_n_miso", n_miso, W);
        cyc(1'b1, 1'b0, 1'b1, "rd_release");

        // Abort after 5 address pulses, then a full transaction
        clr_cnt();
        cyc(1'b0, 1'b0, 1'b0, "ab_start");
        pulses(5, 1'b0, "ab_addr");
        cyc(1'b1, 1'b0, 1'b0, "ab_abort");
        cyc(1'b0, 1'b0, 1'b0, "ab_restart");
        pulses(W - 1, 1'b0, "ab_addr2");
        chk_int("ab_n_addr_early", n_addr, 0);
        pulses(1, 1'b0, "ab_addr2_last");
        chk_int("ab_n_addr_full", n_addr, 1);
        cyc(1'b1, 1'b0, 1'b0, "ab_release");

        // Final address pulse coincident with cs rising
        clr_cnt();
        cyc(1'b0, 1'b0, 1'b0, "co_start");
        pulses(W - 1, 1'b0, "co_addr");
        cyc(1'b1, 1'b1, 1'b0, "co_coincide");
        cyc(1'b1, 1'b0, 1'b0, "co_after");
        chk_int("co_n_addr", n_addr, 0);

        // Asynchronous reset in the middle of a read shift
        cyc(1'b0, 1'b0, 1'b1, "ar_start");
        for (int i = 0; i < W; i++) cyc(1'b0, 1'b1, 1'b1, "ar_addr");
        cyc(1'b0, 1'b0, 1'b1, "ar_latch");
        cyc(1'b0, 1'b0, 1'b1, "ar_load");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, "ar_shift");
        @(negedge clk);
        #2;
        reset = 1'b1;
        busy = 1'b0;
        #1;
        chk("ar_miso_immediate", miso_e, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("ar_edge");
        chk_int("ar_count", int'(dut.u_bit_counter.count), 0);
        @(negedge clk);
        reset = 1'b0;
        cs = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, "ar_idle");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic c;
            if (!busy) c = ($urandom_range(0, 2) == 0);
            else if (p == 2 * W + 2) c = ($urandom_range(0, 3) == 0);
            else c = ($urandom_range(0, 59) == 0);
            cyc(c, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
